// File: rtl/alu_seq_pkg.sv
// Shared constants for the ALU sequencer: opcodes, ALU selects, FSM states, field offsets.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_seq_pkg;

    // Instruction opcodes (instr[15:12])
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_CLR = 4'b0100;
    localparam logic [3:0] OP_LDI = 4'b0101;

    // ALU select encodings
    localparam logic [3:0] SEL_NOP = 4'b0000;
    localparam logic [3:0] SEL_ADD = 4'b0001;
    localparam logic [3:0] SEL_SUB = 4'b0010;
    localparam logic [3:0] SEL_AND = 4'b0011;
    localparam logic [3:0] SEL_OR  = 4'b0100;
    localparam logic [3:0] SEL_CLR = 4'b0101;

    // Sequencer states
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DECODE = 2'd1;
    localparam logic [1:0] EXEC   = 2'd2;
    localparam logic [1:0] WB     = 2'd3;

    // Instruction field offsets (LSB positions)
    localparam int OPC_LSB = 12;
    localparam int RD_LSB  = 10;
    localparam int RS1_LSB = 8;
    localparam int RS2_LSB = 6;
    localparam int IMM_LSB = 0;

    // LDI and illegal opcodes leave the ALU idle.
    function automatic logic [3:0] opc_to_sel(input logic [3:0] opc);
        logic [3:0] sel;
        case (opc)
            OP_ADD:  sel = SEL_ADD;
            OP_SUB:  sel = SEL_SUB;
            OP_AND:  sel = SEL_AND;
            OP_OR:   sel = SEL_OR;
            OP_CLR:  sel = SEL_CLR;
            default: sel = SEL_NOP;
        endcase
        return sel;
    endfunction

    function automatic logic opc_legal(input logic [3:0] opc);
        return (opc <= OP_LDI);
    endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// Register file: NREGS x DATA_W, one synchronous write port, two async read ports plus debug read.
// Latency: write visible on reads the cycle after the write edge; reads combinational.
// Backpressure: none; always accepts writes.
module alu_seq_regfile #(
    parameter int DATA_W = 13,
    parameter int NREGS  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] mem [NREGS];

    // Storage: cleared by reset, single write port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a  = mem[raddr_a];
    assign rdata_b  = mem[raddr_b];
    assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// Sequences an external ALU: fetch one instruction, read operands, drive ALU, write back.
// Latency: 4 cycles per instruction (IDLE accept, DECODE, EXEC, WB); done pulses in WB.
// Backpressure: instr_ready is high only in IDLE; instruction changes while busy are ignored.
module alu_sequencer #(
    parameter int DATA_W = 13,
    parameter int NREGS  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instr,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_sel,
    input  logic [DATA_W-1:0] alu_out,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] result,
    output logic              busy,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);
    import alu_seq_pkg::*;

    logic [1:0]        state;
    logic [15:0]       ir;
    logic              illegal;
    logic [DATA_W-1:0] res;

    logic [3:0]        opc;
    logic [ADDR_W-1:0] rd;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic [7:0]        imm8;
    logic [DATA_W-1:0] rdata_a;
    logic [DATA_W-1:0] rdata_b;
    logic              wr_en;

    assign opc  = ir[OPC_LSB +: 4];
    assign rd   = ir[RD_LSB  +: ADDR_W];
    assign rs1  = ir[RS1_LSB +: ADDR_W];
    assign rs2  = ir[RS2_LSB +: ADDR_W];
    assign imm8 = ir[IMM_LSB +: 8];

    assign instr_ready = (state == IDLE);
    assign busy        = (state != IDLE);
    assign done        = (state == WB);
    assign err         = done & illegal;
    assign wr_en       = done & ~illegal;

    alu_seq_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS),
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we       (wr_en),
        .waddr    (rd),
        .wdata    (res),
        .raddr_a  (rs1),
        .rdata_a  (rdata_a),
        .raddr_b  (rs2),
        .rdata_b  (rdata_b),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // FSM and datapath: operands are registered straight into the ALU ports in DECODE
    // so they are stable for the whole EXEC cycle; alu_sel is only non-zero in EXEC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ir      <= '0;
            illegal <= 1'b0;
            res     <= '0;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_sel <= SEL_NOP;
            result  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        ir    <= instr;
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    alu_a   <= rdata_a;
                    alu_b   <= rdata_b;
                    alu_sel <= opc_to_sel(opc);
                    illegal <= ~opc_legal(opc);
                    state   <= EXEC;
                end
                EXEC: begin
                    case (opc)
                        OP_LDI:  res <= DATA_W'(imm8);
                        OP_CLR:  res <= '0;
                        default: res <= alu_out;
                    endcase
                    alu_sel <= SEL_NOP;
                    state   <= WB;
                end
                default: begin
                    if (!illegal) begin
                        result <= res;
                    end
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;
    localparam int W = 13;

    logic          clk = 1'b0;
    logic          rst;
    logic          instr_valid;
    logic          instr_ready;
    logic [15:0]   instr;
    logic [W-1:0]  alu_a;
    logic [W-1:0]  alu_b;
    logic [3:0]    alu_sel;
    logic [W-1:0]  alu_out;
    logic          done;
    logic          err;
    logic [W-1:0]  result;
    logic          busy;
    logic [1:0]    dbg_addr;
    logic [W-1:0]  dbg_data;

    int checks = 0;
    int errors = 0;

    int done_cnt = 0;
    int err_cnt  = 0;
    int xfer_cnt = 0;
    logic [3:0] last_sel = 4'd0;

    always #5 clk = ~clk;

    alu_sequencer #(.DATA_W(W), .NREGS(4), .ADDR_W(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_sel     (alu_sel),
        .alu_out     (alu_out),
        .done        (done),
        .err         (err),
        .result      (result),
        .busy        (busy),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    // Behavioural ALU attached to the sequencer
    always_comb begin
        alu_out = '0;
        case (alu_sel)
            4'd1: alu_out = alu_a + alu_b;
            4'd2: alu_out = alu_a - alu_b;
            4'd3: alu_out = alu_a & alu_b;
            4'd4: alu_out = alu_a | alu_b;
            default: alu_out = '0;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s timeout at %0t", name, $time);
    endtask

    // ---------------- reference model ----------------
    logic [W-1:0] m_reg [4];
    logic [W-1:0] m_result = '0;
    logic [W-1:0] m_a = '0;
    logic [W-1:0] m_b = '0;
    bit           m_busy = 0;
    int           m_phase = 0;   // cycles since acceptance: 1,2,3 (3 = retire cycle)
    logic [15:0]  m_ir = '0;
    logic [W-1:0] m_val = '0;
    bit           m_ill = 0;
    logic [3:0]   m_sel = '0;

    // Instruction outcome from the architectural rules, using register values at acceptance
    task automatic model_accept(input logic [15:0] ins);
        logic [W-1:0] x;
        logic [W-1:0] y;
        x = m_reg[ins[9:8]];
        y = m_reg[ins[7:6]];
        m_ir  = ins;
        m_ill = 0;
        m_sel = 4'd0;
        m_val = '0;
        case (ins[15:12])
            4'd0: begin m_val = x + y; m_sel = 4'd1; end
            4'd1: begin m_val = x - y; m_sel = 4'd2; end
            4'd2: begin m_val = x & y; m_sel = 4'd3; end
            4'd3: begin m_val = x | y; m_sel = 4'd4; end
            4'd4: begin m_val = '0;    m_sel = 4'd5; end
            4'd5: begin m_val = {5'b0, ins[7:0]}; end
            default: m_ill = 1;
        endcase
        m_busy  = 1;
        m_phase = 1;
    endtask

    // Compare process: every cycle, mid-cycle
    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) m_reg[i] = '0;
            m_result = '0; m_a = '0; m_b = '0; m_busy = 0; m_phase = 0;
            chk("rst_ready", instr_ready, 1);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_err", err, 0);
            chk("rst_sel", alu_sel, 0);
            chk("rst_a", alu_a, 0);
            chk("rst_b", alu_b, 0);
            chk("rst_result", result, 0);
            chk("rst_dbg", dbg_data, 0);
        end else begin
            chk("ready", instr_ready, !m_busy);
            chk("busy", busy, m_busy);
            chk("done", done, m_busy && m_phase == 3);
            chk("err", err, m_busy && m_phase == 3 && m_ill);
            chk("alu_sel", alu_sel, (m_busy && m_phase == 2) ? m_sel : 4'd0);
            chk("alu_a", alu_a, m_a);
            chk("alu_b", alu_b, m_b);
            chk("result", result, m_result);
            chk("dbg_data", dbg_data, m_reg[dbg_addr]);
            if (done) done_cnt++;
            if (err) err_cnt++;
            if (alu_sel != 4'd0) last_sel = alu_sel;
            if (instr_ready && instr_valid) xfer_cnt++;
            if (m_busy) begin
                if (m_phase == 1) begin
                    m_a = m_reg[m_ir[9:8]];
                    m_b = m_reg[m_ir[7:6]];
                    m_phase = 2;
                end else if (m_phase == 2) begin
                    m_phase = 3;
                end else begin
                    if (!m_ill) begin
                        m_reg[m_ir[11:10]] = m_val;
                        m_result = m_val;
                    end
                    m_busy = 0;
                    m_phase = 0;
                end
            end else if (instr_valid) begin
                model_accept(instr);
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [15:0] mk(input logic [3:0] opc, input logic [1:0] rd,
                                       input logic [1:0] rs1, input logic [1:0] rs2);
        return {opc, rd, rs1, rs2, 6'b0};
    endfunction

    function automatic logic [15:0] ldi(input logic [1:0] rd, input logic [7:0] imm);
        return {4'b0101, rd, 2'b00, imm};
    endfunction

    // Present an instruction until accepted; returns just after the accepting edge
    task automatic issue(input logic [15:0] ins);
        int n;
        n = 0;
        instr = ins;
        instr_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (instr_ready) break;
            n++;
            if (n > 20) begin
                timeout("issue");
                break;
            end
        end
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr = 16'($urandom);
    endtask

    // Wait until the sequencer is idle again; returns just after a clock edge
    task automatic wait_idle();
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (instr_ready) break;
            n++;
            if (n > 20) begin
                timeout("wait_idle");
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic read_reg(input string name, input logic [1:0] addr, input logic [W-1:0] exp);
        dbg_addr = addr;
        @(negedge clk);
        chk(name, dbg_data, exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int d0;
        int e0;
        int x0;
        rst = 1'b1;
        instr_valid = 1'b0;
        instr = '0;
        dbg_addr = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // LDI r1,5; LDI r2,3; ADD r0,r1,r2
        d0 = done_cnt;
        issue(ldi(2'd1, 8'd5)); wait_idle();
        issue(ldi(2'd2, 8'd3)); wait_idle();
        issue(mk(4'b0000, 2'd0, 2'd1, 2'd2)); wait_idle();
        chk("add_result", result, 13'd8);
        chk("add_done_count", done_cnt - d0, 3);
        read_reg("add_r0", 2'd0, 13'd8);

        // Wrap: SUB underflow then ADD overflow
        issue(ldi(2'd1, 8'd0)); wait_idle();
        issue(ldi(2'd2, 8'd1)); wait_idle();
        issue(mk(4'b0001, 2'd3, 2'd1, 2'd2)); wait_idle();
        read_reg("sub_wrap_r3", 2'd3, 13'h1FFF);
        issue(mk(4'b0000, 2'd3, 2'd3, 2'd2)); wait_idle();
        read_reg("add_wrap_r3", 2'd3, 13'd0);

        // Logic ops
        issue(ldi(2'd1, 8'hAA)); wait_idle();
        issue(ldi(2'd2, 8'h0F)); wait_idle();
        issue(mk(4'b0010, 2'd0, 2'd1, 2'd2)); wait_idle();
        chk("and_sel", last_sel, 4'b0011);
        read_reg("and_r0", 2'd0, 13'h00A);
        issue(mk(4'b0011, 2'd0, 2'd1, 2'd2)); wait_idle();
        chk("or_sel", last_sel, 4'b0100);
        read_reg("or_r0", 2'd0, 13'h0AF);
        issue(mk(4'b0100, 2'd0, 2'd1, 2'd2)); wait_idle();
        chk("clr_sel", last_sel, 4'b0101);
        read_reg("clr_r0", 2'd0, 13'd0);

        // Illegal opcode targeting r1
        issue(ldi(2'd1, 8'd7)); wait_idle();
        e0 = err_cnt;
        d0 = done_cnt;
        issue(mk(4'b1010, 2'd1, 2'd2, 2'd3)); wait_idle();
        chk("illegal_err", err_cnt - e0, 1);
        chk("illegal_done", done_cnt - d0, 1);
        chk("illegal_result", result, 13'd7);
        read_reg("illegal_r1", 2'd1, 13'd7);

        // Valid held high for 10 cycles
        x0 = xfer_cnt;
        instr = ldi(2'd2, 8'd9);
        instr_valid = 1'b1;
        repeat (10) @(posedge clk);
        #1 instr_valid = 1'b0;
        wait_idle();
        chk("held_valid_xfers", xfer_cnt - x0, 3);

        // Reset during EXEC of ADD r0
        issue(mk(4'b0000, 2'd0, 2'd1, 2'd2));
        @(posedge clk);
        #1;
        d0 = done_cnt;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_ready", instr_ready, 1);
        @(posedge clk);
        #1;
        chk("rst_mid_no_done", done_cnt - d0, 0);
        for (int i = 0; i < 4; i++) read_reg("rst_mid_reg", 2'(i), 13'd0);

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            logic [15:0] r;
            r = 16'($urandom);
            r[15:12] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(6, 15))
                                                   : 4'($urandom_range(0, 5));
            instr = r;
            instr_valid = ($urandom_range(0, 3) != 0);
            dbg_addr = 2'($urandom);
            rst = ($urandom_range(0, 149) == 0);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        instr_valid = 1'b0;
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
